alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Issues nibble commands to an external registered ALU one at a
//            time and queues {result, error} pairs in a small result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_a;
    logic [3:0]         r_b;
    logic [2:0]         r_op;
    logic [7:0]         r_mem_data [FIFO_DEPTH];
    logic               r_mem_err  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_err;
    logic [7:0]         w_push_data;

    // Ready never depends on cmd_valid, so upstream sees no combinational loop
    assign cmd_ready   = (r_state == ST_IDLE) && (r_count < c_DEPTH);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_push      = (r_state == ST_WAIT);
    assign res_valid   = (r_count != '0);
    assign w_pop       = res_valid && res_ready;
    assign busy        = (r_state != ST_IDLE);

    assign w_err       = (r_op[2:1] == 2'b11) || ((r_op == 3'b101) && (r_b == 4'd0));
    assign w_push_data = w_err ? 8'h00 : alu_result;

    assign alu_a  = {4'b0000, r_a};
    assign alu_b  = {4'b0000, r_b};
    assign alu_op = r_op;

    // Head is gated so an empty FIFO (including just after reset) reads zero
    assign res_data = res_valid ? r_mem_data[r_rd_ptr] : 8'h00;
    assign res_err  = res_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= 4'd0;
            r_b  <= 4'd0;
            r_op <= 3'd0;
        end else if (w_accept) begin
            r_a  <= cmd_a;
            r_b  <= cmd_b;
            r_op <= cmd_op;
        end
    end

    // Storage needs no reset: nothing is visible until count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_err[r_wr_ptr]  <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
